// File: rtl/toa_hit_buffer_pkg.sv
// rtl/toa_hit_buffer_pkg.sv - shared TOA hit word layout
// Field widths and bit offsets of the {err, coarse, fine} hit word.
// The encoder and the readout use the same layout.
package toa_hit_buffer_pkg;

    localparam int TOA_COARSE_W   = 3;
    localparam int TOA_FINE_W     = 7;
    localparam int TOA_FINE_LSB   = 0;
    localparam int TOA_COARSE_LSB = TOA_FINE_LSB + TOA_FINE_W;
    localparam int TOA_ERR_BIT    = TOA_COARSE_LSB + TOA_COARSE_W;
    localparam int TOA_WORD_W     = TOA_ERR_BIT + 1;

endpackage

// File: rtl/toa_sync_fifo.sv
// rtl/toa_sync_fifo.sv - first-word-fall-through synchronous FIFO
// Ports:
//   clk, rstn            clock, asynchronous active-low reset
//   push, pushData       write request and write word
//   pop                  remove the head word
//   headData             registered head word; holds the last popped word when empty
//   full, empty          occupancy == DEPTH / occupancy == 0
//   occupancy            number of words stored
module toa_sync_fifo #(
    parameter int WIDTH = 11,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     push,
    input  logic [WIDTH-1:0]         pushData,
    input  logic                     pop,
    output logic [WIDTH-1:0]         headData,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   occupancy
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wrPtr;
    logic [AW:0]      rdPtr;
    logic [AW:0]      rdPtrNext;
    logic [WIDTH-1:0] headNext;
    logic             pushEn;
    logic             popEn;

    assign empty     = (wrPtr == rdPtr);
    assign full      = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
    assign occupancy = wrPtr - rdPtr;

    // A full FIFO still takes a word when the head leaves in the same cycle.
    assign popEn     = pop & ~empty;
    assign pushEn    = push & (~full | popEn);
    assign rdPtrNext = rdPtr + {{AW{1'b0}}, popEn};

    // The head is registered so it can hold the last popped word once empty.
    // If the next head slot is the one being written now, the memory does not
    // hold it yet and the incoming word is taken directly.
    always_comb begin
        headNext = headData;
        if (rdPtrNext == wrPtr) begin
            if (pushEn) begin
                headNext = pushData;
            end
        end else begin
            headNext = mem[rdPtrNext[AW-1:0]];
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wrPtr    <= '0;
            rdPtr    <= '0;
            headData <= '0;
        end else begin
            if (pushEn) begin
                wrPtr <= wrPtr + 1'b1;
            end
            rdPtr    <= rdPtrNext;
            headData <= headNext;
        end
    end

    always_ff @(posedge clk) begin
        if (pushEn) begin
            mem[wrPtr[AW-1:0]] <= pushData;
        end
    end

endmodule

// File: rtl/toa_hit_buffer.sv
// rtl/toa_hit_buffer.sv - TOA hit capture, error filter, FIFO and counters
// Ports:
//   clk, rstn                         clock, asynchronous active-low reset
//   hitValid, coarsePhase, finePhase  encoded hit from the TOA encoder
//   errorFlag                         encoder error flag for this hit
//   dropErr                           discard hits that carry errorFlag
//   clrCnt                            clear errCnt and dropCnt
//   outReady / outValid / outData     readout handshake, {err, coarse, fine}
//   fifoFull, fifoEmpty, occupancy    buffer status
//   errCnt, dropCnt                   saturating error-hit and lost-hit counters
module toa_hit_buffer
    import toa_hit_buffer_pkg::*;
#(
    parameter int DEPTH    = 8,
    parameter int COARSE_W = TOA_COARSE_W,
    parameter int FINE_W   = TOA_FINE_W,
    parameter int CNT_W    = 8
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         hitValid,
    input  logic [COARSE_W-1:0]          coarsePhase,
    input  logic [FINE_W-1:0]            finePhase,
    input  logic                         errorFlag,
    input  logic                         dropErr,
    input  logic                         clrCnt,
    input  logic                         outReady,
    output logic                         outValid,
    output logic [COARSE_W+FINE_W:0]     outData,
    output logic                         fifoFull,
    output logic                         fifoEmpty,
    output logic [$clog2(DEPTH):0]       occupancy,
    output logic [CNT_W-1:0]             errCnt,
    output logic [CNT_W-1:0]             dropCnt
);

    localparam int WORD_W = 1 + COARSE_W + FINE_W;

    logic popFire;
    logic pushCand;
    logic pushAcc;
    logic hitLost;
    logic errHit;

    assign outValid = ~fifoEmpty;
    assign popFire  = outValid & outReady;
    assign pushCand = hitValid & ~(dropErr & errorFlag);
    assign pushAcc  = pushCand & (~fifoFull | popFire);
    assign hitLost  = pushCand & ~pushAcc;
    // Error hits are counted whether or not the filter discards them.
    assign errHit   = hitValid & errorFlag;

    toa_sync_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rstn      (rstn),
        .push      (pushAcc),
        .pushData  ({errorFlag, coarsePhase, finePhase}),
        .pop       (popFire),
        .headData  (outData),
        .full      (fifoFull),
        .empty     (fifoEmpty),
        .occupancy (occupancy)
    );

    // Clear wins over a same-cycle increment.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            errCnt  <= '0;
            dropCnt <= '0;
        end else if (clrCnt) begin
            errCnt  <= '0;
            dropCnt <= '0;
        end else begin
            if (errHit && (errCnt != '1)) begin
                errCnt <= errCnt + CNT_W'(1);
            end
            if (hitLost && (dropCnt != '1)) begin
                dropCnt <= dropCnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_toa_hit_buffer.sv
// tb/tb_toa_hit_buffer.sv - self-checking bench for toa_hit_buffer
module tb_toa_hit_buffer;

    logic        clk = 1'b0;
    logic        rstn;
    logic        hitValid;
    logic [2:0]  coarsePhase;
    logic [6:0]  finePhase;
    logic        errorFlag;
    logic        dropErr;
    logic        clrCnt;
    logic        outReady;
    logic        outValid;
    logic [10:0] outData;
    logic        fifoFull;
    logic        fifoEmpty;
    logic [3:0]  occupancy;
    logic [7:0]  errCnt;
    logic [7:0]  dropCnt;

    int          nTests = 0;
    int          nFail  = 0;
    logic [10:0] sb [$];
    int          mOcc   = 0;
    int          mErr   = 0;
    int          mDrop  = 0;

    always #5 clk = ~clk;

    toa_hit_buffer dut (
        .clk         (clk),
        .rstn        (rstn),
        .hitValid    (hitValid),
        .coarsePhase (coarsePhase),
        .finePhase   (finePhase),
        .errorFlag   (errorFlag),
        .dropErr     (dropErr),
        .clrCnt      (clrCnt),
        .outReady    (outReady),
        .outValid    (outValid),
        .outData     (outData),
        .fifoFull    (fifoFull),
        .fifoEmpty   (fifoEmpty),
        .occupancy   (occupancy),
        .errCnt      (errCnt),
        .dropCnt     (dropCnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nTests++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: compare current outputs with the model, pop the scoreboard on a
    // handshake, push on an accepted hit, then advance to 1 ns after the edge.
    task automatic cyc();
        bit popNow;
        bit cand;
        bit acc;
        check("valid", outValid, (mOcc > 0));
        check("occ", occupancy, mOcc);
        check("errCnt", errCnt, mErr);
        check("dropCnt", dropCnt, mDrop);
        popNow = outReady && (mOcc > 0);
        if (popNow) begin
            if (sb.size() == 0) check("sb_empty", 1, 0);
            else check("pop_data", outData, sb.pop_front());
        end
        cand = hitValid && !(dropErr && errorFlag);
        acc  = cand && ((mOcc < 8) || popNow);
        if (acc) sb.push_back({errorFlag, coarsePhase, finePhase});
        mOcc = mOcc + int'(acc) - int'(popNow);
        if (clrCnt) begin
            mErr  = 0;
            mDrop = 0;
        end else begin
            if (hitValid && errorFlag && mErr < 255) mErr++;
            if (cand && !acc && mDrop < 255) mDrop++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic hit(input logic [2:0] c, input logic [6:0] f, input logic e);
        hitValid    = 1'b1;
        coarsePhase = c;
        finePhase   = f;
        errorFlag   = e;
        cyc();
        hitValid    = 1'b0;
        errorFlag   = 1'b0;
    endtask

    initial begin
        rstn = 1'b0; hitValid = 1'b0; coarsePhase = '0; finePhase = '0;
        errorFlag = 1'b0; dropErr = 1'b0; clrCnt = 1'b0; outReady = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", outValid, 0);
        check("rst_empty", fifoEmpty, 1);
        check("rst_full", fifoFull, 0);
        check("rst_data", outData, 0);
        check("rst_occ", occupancy, 0);
        check("rst_err", errCnt, 0);
        check("rst_drop", dropCnt, 0);
        rstn = 1'b1;

        // single hit, one cycle latency, then popped
        outReady = 1'b1;
        hit(3'b010, 7'd45, 1'b0);
        check("t1_valid", outValid, 1);
        check("t1_data", outData, 11'b0_010_0101101);
        cyc();
        check("t1_empty", fifoEmpty, 1);
        check("t1_hold", outData, 11'b0_010_0101101);

        // fill past full, overflow counted, drain in order
        outReady = 1'b0;
        for (int i = 0; i < 10; i++) hit(3'(i), 7'(i + 10), 1'b0);
        check("t2_full", fifoFull, 1);
        check("t2_occ", occupancy, 8);
        check("t2_drop", dropCnt, 2);
        check("t2_head", outData, {1'b0, 3'd0, 7'd10});
        outReady = 1'b1;
        repeat (8) cyc();
        check("t2_empty", fifoEmpty, 1);

        // full with simultaneous push and pop
        outReady = 1'b0;
        for (int i = 0; i < 8; i++) hit(3'(i), 7'(i + 20), 1'b0);
        check("t3_full", fifoFull, 1);
        outReady = 1'b1;
        hit(3'd5, 7'd99, 1'b0);
        check("t3_occ", occupancy, 8);
        check("t3_drop", dropCnt, 2);
        repeat (8) cyc();
        check("t3_empty", fifoEmpty, 1);
        outReady = 1'b0;

        // error filter
        clrCnt = 1'b1; cyc(); clrCnt = 1'b0;
        check("t4_clr", dropCnt, 0);
        dropErr = 1'b1;
        for (int i = 1; i <= 3; i++) hit(3'd1, 7'(i), 1'b1);
        hit(3'd2, 7'd4, 1'b0);
        check("t4_err3", errCnt, 3);
        check("t4_occ1", occupancy, 1);
        dropErr = 1'b0;
        for (int i = 1; i <= 3; i++) hit(3'd1, 7'(i), 1'b1);
        hit(3'd2, 7'd4, 1'b0);
        check("t4_err6", errCnt, 6);
        check("t4_occ5", occupancy, 5);
        outReady = 1'b1;
        cyc();
        check("t4_errbit", outData[10], 1);
        repeat (4) cyc();
        outReady = 1'b0;

        // saturation and clear priority, hitValid held high
        dropErr = 1'b1; hitValid = 1'b1; errorFlag = 1'b1;
        repeat (300) cyc();
        check("t5_sat", errCnt, 255);
        check("t5_occ", occupancy, 0);
        clrCnt = 1'b1; cyc(); clrCnt = 1'b0;
        hitValid = 1'b0; errorFlag = 1'b0; dropErr = 1'b0;
        check("t5_clr", errCnt, 0);

        // reset in the middle of a stream
        for (int i = 0; i < 5; i++) hit(3'(i), 7'(i + 50), 1'b1);
        check("t6_occ5", occupancy, 5);
        check("t6_err5", errCnt, 5);
        @(negedge clk);
        rstn = 1'b0;
        #1;
        check("t6_valid", outValid, 0);
        check("t6_occ", occupancy, 0);
        check("t6_err", errCnt, 0);
        check("t6_empty", fifoEmpty, 1);
        @(negedge clk);
        rstn = 1'b1;
        sb.delete(); mOcc = 0; mErr = 0; mDrop = 0;
        @(posedge clk);
        #1;
        outReady = 1'b1;
        hit(3'd6, 7'd77, 1'b0);
        check("t6_post_data", outData, {1'b0, 3'd6, 7'd77});
        cyc();
        check("t6_post_empty", fifoEmpty, 1);
        check("sb_drained", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
